// File: rtl/score_display_if.sv
`default_nettype none
// ============================================================================
// Module      : score_display_if
// Description : Score input and seven-segment display bundle for score_display.
// Revision    : 1.0
// ============================================================================
interface score_display_if;
    logic [23:0] score;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic [6:0]  hex4;
    logic [6:0]  hex5;
    logic        busy;
    logic        overflow;

    modport master (
        output score,
        input  hex0, hex1, hex2, hex3, hex4, hex5, busy, overflow
    );

    modport slave (
        input  score,
        output hex0, hex1, hex2, hex3, hex4, hex5, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : Binary score to six-digit seven-segment display using a
//               serial double-dabble conversion. Optional macro
//               LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Revision    : 1.0
// ============================================================================
module score_display #(
    parameter int MAX_SCORE = 999999
) (
    input  wire logic          clk,
    input  wire logic          rst,
    score_display_if.slave     bus
);

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit c_lz_blank = 1'b1;
`else
    localparam bit c_lz_blank = 1'b0;
`endif

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
    localparam logic [1:0] c_st_update = 2'd2;

    localparam logic [23:0] c_max       = 24'(MAX_SCORE);
    localparam logic [6:0]  c_seg_zero  = 7'b1000000;
    localparam logic [6:0]  c_seg_blank = 7'b1111111;
    localparam logic [6:0]  c_hex_rst_upper = c_lz_blank ? c_seg_blank : c_seg_zero;
    localparam logic [4:0]  c_last_shift = 5'd19;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = c_seg_blank;
        endcase
        return s;
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [23:0] r_last_score;
    logic [19:0] r_sr;
    logic [23:0] r_bcd;
    logic [4:0]  r_cnt;
    logic        r_ovf_pend;
    logic [6:0]  r_hex [6];
    logic        r_overflow;
    logic        w_busy;
    logic        w_change;
    logic [23:0] w_bcd_adj;
    logic [6:0]  w_seg [6];

    assign w_change = (bus.score != r_last_score);

    // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
    generate
        for (genvar i = 0; i < 6; i++) begin : g_adj
            assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                         (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
        end
    endgenerate

    generate
        for (genvar i = 0; i < 6; i++) begin : g_seg
            if (i == 0) begin : g_units
                assign w_seg[i] = seg7(r_bcd[3:0]);
            end else begin : g_upper
                logic w_lead_zero;
                assign w_lead_zero = c_lz_blank && (r_bcd[23:4*i] == '0);
                assign w_seg[i]    = w_lead_zero ? c_seg_blank : seg7(r_bcd[4*i +: 4]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (w_change) w_state_next = c_st_shift;
            c_st_shift:  if (r_cnt == c_last_shift) w_state_next = c_st_update;
            c_st_update: w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_busy = (r_state != c_st_idle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_score <= '0;
            r_sr         <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_ovf_pend   <= 1'b0;
            r_overflow   <= 1'b0;
            r_hex[0]     <= c_seg_zero;
            for (int i = 1; i < 6; i++) begin
                r_hex[i] <= c_hex_rst_upper;
            end
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_change) begin
                        r_sr         <= (bus.score > c_max) ? c_max[19:0] : bus.score[19:0];
                        r_ovf_pend   <= (bus.score > c_max);
                        r_last_score <= bus.score;
                        r_bcd        <= '0;
                        r_cnt        <= '0;
                    end
                end
                c_st_shift: begin
                    r_bcd <= {w_bcd_adj[22:0], r_sr[19]};
                    r_sr  <= {r_sr[18:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                end
                c_st_update: begin
                    r_overflow <= r_ovf_pend;
                    for (int i = 0; i < 6; i++) begin
                        r_hex[i] <= w_seg[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hex0     = r_hex[0];
    assign bus.hex1     = r_hex[1];
    assign bus.hex2     = r_hex[2];
    assign bus.hex3     = r_hex[3];
    assign bus.hex4     = r_hex[4];
    assign bus.hex5     = r_hex[5];
    assign bus.busy     = w_busy;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
